// File: rtl/procfilt_pkg.sv
// Shared control-word layout and MEM-stage FSM encoding for the processor pipeline.
package procfilt_pkg;

    localparam int CTRL_W      = 17;
    localparam int CTRL_REG_WR = 0;
    localparam int CTRL_MEM_RD = 3;
    localparam int CTRL_MEM_WR = 4;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues req/ack data-memory accesses, stalls upstream while
// one is outstanding, and registers write-back results. Optional: MEM_TIMEOUT_EN.
import procfilt_pkg::*;

module mem_access_stage #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [31:0]       i_srcReg,
    input  logic [3:0]        i_srcRegDir,
    input  logic [31:0]       i_alu,
    input  logic [31:0]       i_Robj,
    output logic              o_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [31:0]       o_wbData,
    output logic [3:0]        o_srcRegDir,
    output logic [31:0]       o_Robj,
    output logic              o_err
);

    mem_state_t  state;
    logic        memop;
    logic        timeout_hit;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_err;
    logic [3:0]  dir_q;
    logic [31:0] robj_q;
    logic [31:0] alu_q;

    assign memop = i_valid & (i_ctrl[CTRL_MEM_RD] | i_ctrl[CTRL_MEM_WR]);

    // NOTE: o_stall is decoded from the current state and inputs only, so the
    // hazard is visible to upstream in the same cycle the memop appears.
    assign o_stall = ((state == ST_IDLE) & memop)
                   | ((state == ST_WAIT) & ~mem_ack & ~timeout_hit);

    // An aborted access must not be allowed to write the register file.
    always_comb begin
        ctrl_err              = ctrl_q;
        ctrl_err[CTRL_REG_WR] = 1'b0;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == ST_WAIT) & (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err    <= timeout_hit & ~mem_ack;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    // NOTE: every register here is a flop updated with <=; reading any of them
    // in this block sees the value from before the current edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            o_valid     <= 1'b0;
            o_ctrl      <= '0;
            o_wbData    <= '0;
            o_srcRegDir <= '0;
            o_Robj      <= '0;
            ctrl_q      <= '0;
            dir_q       <= '0;
            robj_q      <= '0;
            alu_q       <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (memop) begin
                        mem_req   <= 1'b1;
                        mem_we    <= i_ctrl[CTRL_MEM_WR];
                        mem_addr  <= i_alu[ADDR_W-1:0];
                        mem_wdata <= i_srcReg;
                        ctrl_q    <= i_ctrl;
                        dir_q     <= i_srcRegDir;
                        robj_q    <= i_Robj;
                        alu_q     <= i_alu;
                        state     <= ST_WAIT;
                    end else if (i_valid) begin
                        o_valid     <= 1'b1;
                        o_ctrl      <= i_ctrl;
                        o_wbData    <= i_alu;
                        o_srcRegDir <= i_srcRegDir;
                        o_Robj      <= i_Robj;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        o_valid     <= 1'b1;
                        o_ctrl      <= ctrl_q;
                        o_wbData    <= mem_we ? alu_q : mem_rdata;
                        o_srcRegDir <= dir_q;
                        o_Robj      <= robj_q;
                        state       <= ST_IDLE;
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        o_valid     <= 1'b1;
                        o_ctrl      <= ctrl_err;
                        o_wbData    <= alu_q;
                        o_srcRegDir <= dir_q;
                        o_Robj      <= robj_q;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: each issued instruction pushes its expected
// write-back record; a negedge monitor pops and compares whenever o_valid is seen.
module tb_mem_access_stage;

    typedef struct packed {
        logic [16:0] ctrl;
        logic [31:0] wb;
        logic [3:0]  dir;
        logic [31:0] robj;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [16:0] i_ctrl;
    logic [31:0] i_srcReg;
    logic [3:0]  i_srcRegDir;
    logic [31:0] i_alu;
    logic [31:0] i_Robj;
    logic        o_stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        o_valid;
    logic [16:0] o_ctrl;
    logic [31:0] o_wbData;
    logic [3:0]  o_srcRegDir;
    logic [31:0] o_Robj;
    logic        o_err;

    int   tests_run = 0;
    int   fails     = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ctrl(i_ctrl), .i_srcReg(i_srcReg),
        .i_srcRegDir(i_srcRegDir), .i_alu(i_alu), .i_Robj(i_Robj),
        .o_stall(o_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .o_valid(o_valid), .o_ctrl(o_ctrl), .o_wbData(o_wbData),
        .o_srcRegDir(o_srcRegDir), .o_Robj(o_Robj), .o_err(o_err)
    );

    // Scoreboard consumer
    always @(negedge clk) begin : monitor
        exp_t got, want;
        if (rst === 1'b0 && o_valid === 1'b1) begin
            tests_run++;
            got = '{ctrl: o_ctrl, wb: o_wbData, dir: o_srcRegDir, robj: o_Robj};
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: o_valid with nothing expected, got %h", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL sb_result: got %h expected %h", got, want);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_ctrl  = 17'h1_FFE7;
        i_alu   = 32'hFFFF_FFFF;
        repeat (n) @(negedge clk);
    endtask

    // Present one instruction at a negedge and follow it through the handshake;
    // returns at the negedge where its result should be on the outputs.
    task automatic issue(input logic [16:0] ctrl, input logic [31:0] alu, input logic [31:0] src,
                         input logic [3:0] dir, input logic [31:0] robj,
                         input int ack_delay, input logic [31:0] rdata, input string name);
        logic is_mem, is_wr;
        int   stalls;
        exp_t e;
        is_mem = ctrl[3] | ctrl[4];
        is_wr  = ctrl[4];
        i_valid = 1'b1; i_ctrl = ctrl; i_alu = alu; i_srcReg = src;
        i_srcRegDir = dir; i_Robj = robj;
        e = '{ctrl: ctrl, wb: (is_mem && !is_wr) ? rdata : alu, dir: dir, robj: robj};
        sb.push_back(e);
        #1;
        tests_run++;
        if (o_stall !== is_mem) begin
            fails++;
            $display("FAIL %s_issue_stall: got %b expected %b", name, o_stall, is_mem);
        end
        if (is_mem) begin
            stalls = 1;
            @(negedge clk);
            tests_run++;
            if ({mem_req, mem_we, mem_addr, o_valid} !== {1'b1, is_wr, alu[15:0], 1'b0}) begin
                fails++;
                $display("FAIL %s_req: req/we/addr/valid got %b/%b/%h/%b expected 1/%b/%h/0",
                         name, mem_req, mem_we, mem_addr, o_valid, is_wr, alu[15:0]);
            end
            if (is_wr) begin
                tests_run++;
                if (mem_wdata !== src) begin
                    fails++;
                    $display("FAIL %s_wdata: got %h expected %h", name, mem_wdata, src);
                end
            end
            for (int k = 0; k < ack_delay; k++) begin
                if (o_stall === 1'b1 && mem_req === 1'b1) stalls++;
                @(negedge clk);
            end
            mem_ack = 1'b1; mem_rdata = rdata;
            #1;
            tests_run++;
            if (o_stall !== 1'b0) begin
                fails++;
                $display("FAIL %s_ack_stall: got %b expected 0", name, o_stall);
            end
            tests_run++;
            if (stalls != ack_delay + 1) begin
                fails++;
                $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stalls, ack_delay + 1);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'hBAD0_0BAD;
        tests_run++;
        if ({o_valid, mem_req} !== 2'b10) begin
            fails++;
            $display("FAIL %s_done: valid/req got %b/%b expected 1/0", name, o_valid, mem_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        i_valid = 1'b0; i_ctrl = '0; i_srcReg = '0; i_srcRegDir = '0; i_alu = '0; i_Robj = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({o_valid, mem_req, mem_we, o_err, o_stall} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: valid/req/we/err/stall got %b%b%b%b%b expected 00000",
                     o_valid, mem_req, mem_we, o_err, o_stall);
        end
        tests_run++;
        if ({mem_addr, mem_wdata, o_ctrl, o_wbData, o_srcRegDir, o_Robj} !== '0) begin
            fails++;
            $display("FAIL reset_data: addr %h wdata %h ctrl %h wb %h dir %h robj %h expected all 0",
                     mem_addr, mem_wdata, o_ctrl, o_wbData, o_srcRegDir, o_Robj);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu_op();
        issue(17'h0_0001, 32'h0000_1234, 32'h0, 4'h3, 32'h1111_0000, 0, 32'h0, "alu1");
        issue(17'h1_0005, 32'hCAFE_F00D, 32'h0, 4'hF, 32'h2222_0000, 0, 32'h0, "alu2");
        idle(1);
    endtask

    task automatic test_idle_hold();
        issue(17'h0_0001, 32'h0BAD_CAFE, 32'h0, 4'h9, 32'h5A5A_0001, 0, 32'h0, "hold");
        idle(3);
        tests_run++;
        if ({o_valid, o_wbData, o_srcRegDir, o_Robj} !== {1'b0, 32'h0BAD_CAFE, 4'h9, 32'h5A5A_0001}) begin
            fails++;
            $display("FAIL idle_hold: valid/wb/dir/robj got %b/%h/%h/%h expected 0/0badcafe/9/5a5a0001",
                     o_valid, o_wbData, o_srcRegDir, o_Robj);
        end
    endtask

    task automatic test_load();
        issue(17'h0_0009, 32'h0000_0040, 32'h7777_7777, 4'h5, 32'h3333_0000, 3, 32'hDEAD_BEEF, "load");
        idle(1);
    endtask

    task automatic test_store();
        issue(17'h0_0010, 32'h0000_0080, 32'hA5A5_A5A5, 4'h6, 32'h4444_0000, 0, 32'h1357_9BDF, "store");
        idle(1);
    endtask

    task automatic test_both_bits();
        issue(17'h0_0018, 32'h0001_00C4, 32'h0F0F_0F0F, 4'h7, 32'h5555_0000, 1, 32'h2468_ACE0, "rdwr");
        idle(1);
    endtask

    task automatic test_reset_in_wait();
        i_valid = 1'b1; i_ctrl = 17'h0_0009; i_alu = 32'h0000_0200; i_srcRegDir = 4'h2;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rstwait_req: got %b expected 1", mem_req);
        end
        rst = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_req, o_valid, o_stall} !== 3'b000) begin
            fails++;
            $display("FAIL rstwait_abort: req/valid/stall got %b%b%b expected 000", mem_req, o_valid, o_stall);
        end
        mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
        #1;
        tests_run++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL stray_ack_stall: got %b expected 0", o_stall);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_req, o_valid} !== 2'b00) begin
            fails++;
            $display("FAIL stray_ack_ignored: req/valid got %b%b expected 00", mem_req, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        issue(17'h0_0010, 32'h0000_1000, 32'h1111_2222, 4'h1, 32'hAAAA_0001, 2, 32'h0, "b2b_st");
        issue(17'h0_0009, 32'h0000_1004, 32'h0, 4'h2, 32'hAAAA_0002, 0, 32'h8765_4321, "b2b_ld");
        issue(17'h0_0001, 32'h0000_5555, 32'h0, 4'h3, 32'hAAAA_0003, 0, 32'h0, "b2b_alu1");
        issue(17'h0_0003, 32'h0000_6666, 32'h0, 4'h4, 32'hAAAA_0004, 0, 32'h0, "b2b_alu2");
        idle(2);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n, bad;
        i_valid = 1'b1; i_ctrl = 17'h0_0009; i_alu = 32'h0000_0100; i_srcReg = '0;
        i_srcRegDir = 4'hA; i_Robj = 32'h9999_0000;
        sb.push_back('{ctrl: 17'h0_0008, wb: 32'h0000_0100, dir: 4'hA, robj: 32'h9999_0000});
        @(negedge clk);
        n = 0; bad = 0;
        while (o_err !== 1'b1 && n < 20) begin
            if (o_stall !== (n < 7)) bad++;
            n++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        tests_run++;
        if (n != 8 || bad != 0) begin
            fails++;
            $display("FAIL timeout_cycles: wait %0d bad_stall %0d expected 8 and 0", n, bad);
        end
        tests_run++;
        if ({o_valid, mem_req, o_ctrl[0]} !== 3'b100) begin
            fails++;
            $display("FAIL timeout_out: valid/req/regwr got %b%b%b expected 100", o_valid, mem_req, o_ctrl[0]);
        end
        @(negedge clk);
        tests_run++;
        if (o_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_pulse: o_err got %b expected 0", o_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_op();
        test_idle_hold();
        test_load();
        test_store();
        test_both_bits();
        test_reset_in_wait();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        idle(2);
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d results never seen, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
